// File: rtl/axi_resp_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : axi_resp_packetizer
// Purpose  : Pops one granted B/R beat and serialises it into a NoC packet.
// Revision : 1.0 - initial release
// ============================================================================
module axi_resp_packetizer #(
  parameter int TID_W   = 4,
  parameter int DATA_W  = 64,
  parameter int FLIT_PW = 32,
  parameter int DST_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         active_channel,
  output logic [1:0]         update_pri,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [TID_W-1:0]   b_id,
  input  logic [1:0]         b_resp,
  input  logic [DST_W-1:0]   b_dst,
  input  logic               r_valid,
  output logic               r_ready,
  input  logic [TID_W-1:0]   r_id,
  input  logic [1:0]         r_resp,
  input  logic               r_last,
  input  logic [DATA_W-1:0]  r_data,
  input  logic [DST_W-1:0]   r_dst,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic               flit_head,
  output logic               flit_tail,
  output logic [FLIT_PW-1:0] flit_data
);

  localparam int NDF     = DATA_W / FLIT_PW;
  localparam int c_CNT_W = (NDF > 1) ? $clog2(NDF) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(NDF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ch;
  logic [TID_W-1:0]     r_cap_id;
  logic [1:0]           r_cap_resp;
  logic                 r_cap_last;
  logic [DST_W-1:0]     r_cap_dst;
  logic [DATA_W-1:0]    r_cap_data;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_take_b;
  logic                 w_take_r;
  logic [FLIT_PW-1:0]   w_hdr;
  logic [FLIT_PW-1:0]   w_data_flit;

  always_comb begin
    w_hdr                               = '0;
    w_hdr[DST_W-1:0]                    = r_cap_dst;
    w_hdr[DST_W]                        = r_ch;
    w_hdr[DST_W+1 +: TID_W]             = r_cap_id;
    w_hdr[DST_W+TID_W+1 +: 2]           = r_cap_resp;
    w_hdr[DST_W+TID_W+3]                = r_cap_last;
  end

  assign w_data_flit = r_cap_data[r_cnt*FLIT_PW +: FLIT_PW];

  // Pop strobes are suppressed during reset because the capture would be lost.
  always_comb begin
    w_state_nxt = r_state;
    w_take_b    = 1'b0;
    w_take_r    = 1'b0;
    flit_valid  = 1'b0;
    flit_head   = 1'b0;
    flit_tail   = 1'b0;
    flit_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (rst) begin
          if (active_channel[1]) begin
            w_take_r    = 1'b1;
            w_state_nxt = S_HDR;
          end else if (active_channel[0]) begin
            w_take_b    = 1'b1;
            w_state_nxt = S_HDR;
          end
        end
      end
      S_HDR: begin
        flit_valid = 1'b1;
        flit_head  = 1'b1;
        flit_tail  = ~r_ch;
        flit_data  = w_hdr;
        if (flit_ready) w_state_nxt = r_ch ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        flit_valid = 1'b1;
        flit_tail  = (r_cnt == c_LAST_CNT);
        flit_data  = w_data_flit;
        if (flit_ready && (r_cnt == c_LAST_CNT)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign b_ready    = w_take_b;
  assign r_ready    = w_take_r;
  assign update_pri = {w_take_r, w_take_b};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ch       <= 1'b0;
      r_cap_id   <= '0;
      r_cap_resp <= '0;
      r_cap_last <= 1'b0;
      r_cap_dst  <= '0;
      r_cap_data <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_r) begin
        r_ch       <= 1'b1;
        r_cap_id   <= r_id;
        r_cap_resp <= r_resp;
        r_cap_last <= r_last;
        r_cap_dst  <= r_dst;
        r_cap_data <= r_data;
      end else if (w_take_b) begin
        r_ch       <= 1'b0;
        r_cap_id   <= b_id;
        r_cap_resp <= b_resp;
        r_cap_last <= 1'b1;
        r_cap_dst  <= b_dst;
        r_cap_data <= '0;
      end
      if (r_state == S_HDR && flit_ready) begin
        r_cnt <= '0;
      end else if (r_state == S_DATA && flit_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    active_channel != 2'b11);
  a_b_granted_valid: assert property (@(posedge clk) disable iff (!rst)
    w_take_b |-> b_valid);
  a_r_granted_valid: assert property (@(posedge clk) disable iff (!rst)
    w_take_r |-> r_valid);

endmodule
`default_nettype wire
